// File: rtl/rle_pixel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rle_pixel_decoder
// Purpose  : Expands run-length instructions into a registered RRGGBB pixel
//            stream, with a one-word prefetch buffer and reader throttling.
// Revision : 1.0
// ============================================================================
module rle_pixel_decoder #(
  parameter int LEN_W   = 12,
  parameter int COLOR_W = 6,
  parameter int HOLDOFF = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LEN_W+COLOR_W-1:0] instruction,
  input  logic                     valid,
  output logic                     shift_data,
  input  logic                     pixel_req,
  output logic [COLOR_W-1:0]       pixel_rgb,
  output logic                     pixel_valid,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int INSTR_W = LEN_W + COLOR_W;
  localparam int REM_W   = LEN_W + 1;
  localparam int HO_W    = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic               buf_full_q, buf_full_d;
  logic [COLOR_W-1:0] act_rgb_q, act_rgb_d;
  logic [REM_W-1:0]   act_rem_q, act_rem_d;
  logic               act_busy_q, act_busy_d;
  logic [HO_W-1:0]    holdoff_q, holdoff_d;
  logic [COLOR_W-1:0] pixel_rgb_q, pixel_rgb_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic               underrun_q, underrun_d;
  logic               shift_data_q;

  logic [LEN_W-1:0]   buf_len;
  logic [COLOR_W-1:0] buf_rgb;
  logic               capture;

  assign buf_len = buf_instr_q[INSTR_W-1:COLOR_W];
  assign buf_rgb = buf_instr_q[COLOR_W-1:0];
  // Capture only looks at the buffer state at the start of the cycle, so a
  // buffer move and a capture can never collide.
  assign capture = valid && !buf_full_q && (holdoff_q == '0);

  always_comb begin
    buf_instr_d   = buf_instr_q;
    buf_full_d    = buf_full_q;
    act_rgb_d     = act_rgb_q;
    act_rem_d     = act_rem_q;
    act_busy_d    = act_busy_q;
    holdoff_d     = holdoff_q;
    pixel_rgb_d   = '0;
    pixel_valid_d = 1'b0;
    underrun_d    = underrun_q && !underrun_clr;

    if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HO_W'(1);
    end

    if (pixel_req) begin
      if (act_busy_q) begin
        pixel_rgb_d   = act_rgb_q;
        pixel_valid_d = 1'b1;
        act_rem_d     = act_rem_q - REM_W'(1);
        act_busy_d    = (act_rem_q != REM_W'(1));
      end else if (buf_full_q) begin
        // Fast load: first pixel leaves now, act_rem counts the rest.
        pixel_rgb_d   = buf_rgb;
        pixel_valid_d = 1'b1;
        act_rgb_d     = buf_rgb;
        act_rem_d     = {1'b0, buf_len};
        act_busy_d    = (buf_len != '0);
        buf_full_d    = 1'b0;
      end else begin
        underrun_d    = 1'b1;
      end
    end else if (!act_busy_q && buf_full_q) begin
      act_rgb_d  = buf_rgb;
      act_rem_d  = {1'b0, buf_len} + REM_W'(1);
      act_busy_d = 1'b1;
      buf_full_d = 1'b0;
    end

    if (capture) begin
      buf_instr_d = instruction;
      buf_full_d  = 1'b1;
      holdoff_d   = HO_W'(HOLDOFF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr_q   <= '0;
      buf_full_q    <= 1'b0;
      act_rgb_q     <= '0;
      act_rem_q     <= '0;
      act_busy_q    <= 1'b0;
      holdoff_q     <= '0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      shift_data_q  <= 1'b0;
    end else begin
      buf_instr_q   <= buf_instr_d;
      buf_full_q    <= buf_full_d;
      act_rgb_q     <= act_rgb_d;
      act_rem_q     <= act_rem_d;
      act_busy_q    <= act_busy_d;
      holdoff_q     <= holdoff_d;
      pixel_rgb_q   <= pixel_rgb_d;
      pixel_valid_q <= pixel_valid_d;
      underrun_q    <= underrun_d;
      shift_data_q  <= !buf_full_d;
    end
  end

  assign shift_data  = shift_data_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_pixel_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rle_pixel_decoder
// Purpose  : Bench for rle_pixel_decoder against a pixel-queue reference.
// Revision : 1.0
// ============================================================================
module tb_rle_pixel_decoder;

  localparam int LEN_W   = 12;
  localparam int COLOR_W = 6;
  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] instruction = '0;
  logic        valid = 1'b0;
  logic        pixel_req = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        shift_data;
  logic [5:0]  pixel_rgb;
  logic        pixel_valid;
  logic        underrun;

  always #5 clk = ~clk;

  rle_pixel_decoder #(
    .LEN_W   (LEN_W),
    .COLOR_W (COLOR_W),
    .HOLDOFF (HOLDOFF)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .valid        (valid),
    .shift_data   (shift_data),
    .pixel_req    (pixel_req),
    .pixel_rgb    (pixel_rgb),
    .pixel_valid  (pixel_valid),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the active run is an expanded queue of pending pixel colours.
  logic [5:0]  m_pix[$];
  logic        m_buf_full;
  logic [17:0] m_buf;
  logic        m_und;
  int          m_cyc;
  int          m_last_cap;
  logic [5:0]  exp_rgb;
  logic        exp_pv;
  logic        exp_sd;

  int          obs_cnt;
  logic [5:0]  obs_col;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pix.delete();
    m_buf_full = 1'b0;
    m_buf      = '0;
    m_und      = 1'b0;
    m_cyc      = 0;
    m_last_cap = -1000;
    exp_rgb    = '0;
    exp_pv     = 1'b0;
    exp_sd     = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [17:0] ins, input logic pr, input logic clr);
    logic       cap;
    int         len;
    logic [5:0] col;
    m_cyc++;
    cap     = v && !m_buf_full && ((m_cyc - m_last_cap) > HOLDOFF);
    len     = int'(m_buf[17:6]);
    col     = m_buf[5:0];
    exp_rgb = '0;
    exp_pv  = 1'b0;
    if (clr) m_und = 1'b0;
    if (pr) begin
      if (m_pix.size() != 0) begin
        exp_rgb = m_pix.pop_front();
        exp_pv  = 1'b1;
      end else if (m_buf_full) begin
        exp_rgb = col;
        exp_pv  = 1'b1;
        for (int k = 0; k < len; k++) m_pix.push_back(col);
        m_buf_full = 1'b0;
      end else begin
        m_und = 1'b1;
      end
    end else if (m_pix.size() == 0 && m_buf_full) begin
      for (int k = 0; k < len + 1; k++) m_pix.push_back(col);
      m_buf_full = 1'b0;
    end
    if (cap) begin
      m_buf      = ins;
      m_buf_full = 1'b1;
      m_last_cap = m_cyc;
    end
    exp_sd = !m_buf_full;
  endtask

  task automatic check_outputs(input string phase);
    check_eq({phase, ".pixel_rgb"},   32'(pixel_rgb),   32'(exp_rgb));
    check_eq({phase, ".pixel_valid"}, 32'(pixel_valid), 32'(exp_pv));
    check_eq({phase, ".underrun"},    32'(underrun),    32'(m_und));
    check_eq({phase, ".shift_data"},  32'(shift_data),  32'(exp_sd));
  endtask

  task automatic step(input string phase, input logic v, input logic [17:0] ins,
                      input logic pr, input logic clr);
    @(negedge clk);
    valid        = v;
    instruction  = v ? ins : 18'($urandom);
    pixel_req    = pr;
    underrun_clr = clr;
    @(posedge clk);
    model_update(v, ins, pr, clr);
    #1;
    check_outputs(phase);
    if (pixel_valid === 1'b1 && pixel_rgb === obs_col) obs_cnt++;
  endtask

  logic [17:0] b2b [3];
  logic [17:0] w;

  initial begin
    b2b[0] = {12'd0, 6'h03};
    b2b[1] = {12'd1, 6'h0C};
    b2b[2] = {12'd0, 6'h30};
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word of three pixels
    obs_col = 6'h2A;
    obs_cnt = 0;
    step("single", 1'b1, {12'd2, 6'h2A}, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("single", 1'b0, '0, 1'b1, 1'b0);
    check_eq("single.run_count", 32'(obs_cnt), 32'd3);

    // Back-to-back words every 6 cycles
    for (int i = 0; i < 20; i++)
      step("b2b", (i % 6 == 0) && (i < 18), b2b[(i / 6) % 3], i >= 2, 1'b0);

    // Stale valid held for three cycles
    step("stale", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("stale", 1'b1, {12'd1, 6'h3F}, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("stale", 1'b0, '0, 1'b1, 1'b0);

    // Underrun and clear, including a same-cycle set and clear
    step("undr", 1'b0, '0, 1'b0, 1'b1);
    step("undr", 1'b0, '0, 1'b1, 1'b0);
    step("undr", 1'b0, '0, 1'b0, 1'b1);
    step("undr", 1'b0, '0, 1'b1, 1'b1);
    step("undr", 1'b0, '0, 1'b0, 1'b0);

    // Maximum run length followed by a short run
    obs_col = 6'h15;
    obs_cnt = 0;
    step("maxlen", 1'b1, {12'hFFF, 6'h15}, 1'b0, 1'b0);
    step("maxlen", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4106; i++)
      step("maxlen", i == 100, {12'd3, 6'h2A}, 1'b1, 1'b0);
    check_eq("maxlen.run_count", 32'(obs_cnt), 32'd4096);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      w = {($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 40)) : 12'($urandom_range(0, 5)),
           6'($urandom)};
      step("rand", $urandom_range(0, 3) == 0, w, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 100; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a 100-pixel run
    step("midrst", 1'b1, {12'd99, 6'h11}, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step("midrst", 1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst.async_rgb",   32'(pixel_rgb),   32'd0);
    check_eq("midrst.async_valid", 32'(pixel_valid), 32'd0);
    check_eq("midrst.async_sd",    32'(shift_data),  32'd0);
    valid     = 1'b0;
    pixel_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_col = 6'h2D;
    obs_cnt = 0;
    step("postrst", 1'b0, '0, 1'b0, 1'b0);
    step("postrst", 1'b1, {12'd4, 6'h2D}, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("postrst", 1'b0, '0, 1'b1, 1'b0);
    check_eq("postrst.run_count", 32'(obs_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
